nco_voice_allocator: RTL and testbench

//  Polyphonic voice allocator/scheduler between the SPI command decoder and the bank of NCOs.

---
 rtl/nco_voice_allocator_if.sv | 29 ++
 rtl/nco_voice_allocator.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_nco_voice_allocator.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nco_voice_allocator_if.sv
//------------------------------------------------------------------------------
// nco_voice_allocator_if
// Command handshake between the SPI command decoder and the voice allocator.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface nco_voice_allocator_if #(
  parameter int NCO_ADDR_BITS = 8
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_type;
  logic [6:0]               cmd_note;
  logic [15:0]              cmd_divider;
  logic [NCO_ADDR_BITS-1:0] cmd_phase;

  modport master (
    output cmd_valid, cmd_type, cmd_note, cmd_divider, cmd_phase,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_note, cmd_divider, cmd_phase,
    output cmd_ready
  );
endinterface

`default_nettype wire

// File: rtl/nco_voice_allocator.sv
//------------------------------------------------------------------------------
// nco_voice_allocator
// Polyphonic voice allocator: maps note commands onto NCO voices, optional
// oldest-voice stealing when the VOICE_STEAL_EN macro is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nco_voice_allocator #(
  parameter int          NUM_VOICES    = 4,
  parameter int          NCO_ADDR_BITS = 8,
  parameter int          AGE_BITS      = 4,
  parameter logic [15:0] DEFAULT_DIV   = 16'hFFFF
) (
  input  wire logic                                sys_clk,
  input  wire logic                                sys_rst,
  nco_voice_allocator_if.slave                     cmd,
  output logic [16*NUM_VOICES-1:0]                 voice_divider,
  output logic [NCO_ADDR_BITS*NUM_VOICES-1:0]      voice_phase,
  output logic [NUM_VOICES-1:0]                    voice_apply,
  output logic [NUM_VOICES-1:0]                    voice_gate,
  output logic                                     steal_pulse,
  output logic                                     drop_pulse
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] SCAN_LAST = IDX_W'(NUM_VOICES - 1);

  localparam logic [1:0] CMD_NOTE_ON  = 2'd0;
  localparam logic [1:0] CMD_NOTE_OFF = 2'd1;
  localparam logic [1:0] CMD_ALL_OFF  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               type_q, type_d;
  logic [6:0]               note_q, note_d;
  logic [15:0]              div_q, div_d;
  logic [NCO_ADDR_BITS-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]         scan_idx_q, scan_idx_d;
  logic                     match_found_q, match_found_d;
  logic [IDX_W-1:0]         match_idx_q, match_idx_d;
  logic                     free_found_q, free_found_d;
  logic [IDX_W-1:0]         free_idx_q, free_idx_d;

  logic [NUM_VOICES-1:0]    gate_q, gate_d;
  logic [6:0]               vnote_q  [NUM_VOICES];
  logic [6:0]               vnote_d  [NUM_VOICES];
  logic [15:0]              vdiv_q   [NUM_VOICES];
  logic [15:0]              vdiv_d   [NUM_VOICES];
  logic [NCO_ADDR_BITS-1:0] vphase_q [NUM_VOICES];
  logic [NCO_ADDR_BITS-1:0] vphase_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]    apply_q, apply_d;
  logic                     drop_q, drop_d;

  logic                     tgt_valid;
  logic [IDX_W-1:0]         tgt_idx;

`ifdef VOICE_STEAL_EN
  logic                     old_found_q, old_found_d;
  logic [IDX_W-1:0]         old_idx_q, old_idx_d;
  logic [AGE_BITS-1:0]      old_age_q, old_age_d;
  logic [AGE_BITS-1:0]      age_q [NUM_VOICES];
  logic [AGE_BITS-1:0]      age_d [NUM_VOICES];
  logic                     steal_q, steal_d;
  logic                     stolen;
`endif

  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    note_d        = note_q;
    div_d         = div_q;
    phase_d       = phase_q;
    scan_idx_d    = scan_idx_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    gate_d        = gate_q;
    vnote_d       = vnote_q;
    vdiv_d        = vdiv_q;
    vphase_d      = vphase_q;
    apply_d       = '0;
    drop_d        = 1'b0;
    tgt_valid     = 1'b0;
    tgt_idx       = '0;
`ifdef VOICE_STEAL_EN
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    age_d         = age_q;
    steal_d       = 1'b0;
    stolen        = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          type_d        = cmd.cmd_type;
          note_d        = cmd.cmd_note;
          div_d         = cmd.cmd_divider;
          phase_d       = cmd.cmd_phase;
          scan_idx_d    = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
`ifdef VOICE_STEAL_EN
          old_found_d   = 1'b0;
`endif
          if (cmd.cmd_type == CMD_NOTE_ON || cmd.cmd_type == CMD_NOTE_OFF) begin
            state_d = ST_SCAN;
          end else if (cmd.cmd_type == CMD_ALL_OFF) begin
            state_d = ST_COMMIT;
          end
        end
      end

      ST_SCAN: begin
        // Ascending scan: first hit wins for match/free, strict > keeps lowest index on age ties.
        if (gate_q[scan_idx_q] && vnote_q[scan_idx_q] == note_q && !match_found_q) begin
          match_found_d = 1'b1;
          match_idx_d   = scan_idx_q;
        end
        if (!gate_q[scan_idx_q] && !free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = scan_idx_q;
        end
`ifdef VOICE_STEAL_EN
        if (gate_q[scan_idx_q] && (!old_found_q || age_q[scan_idx_q] > old_age_q)) begin
          old_found_d = 1'b1;
          old_idx_d   = scan_idx_q;
          old_age_d   = age_q[scan_idx_q];
        end
`endif
        if (scan_idx_q == SCAN_LAST) begin
          state_d = ST_COMMIT;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        case (type_q)
          CMD_NOTE_ON: begin
            if (match_found_q) begin
              tgt_valid = 1'b1;
              tgt_idx   = match_idx_q;
            end else if (free_found_q) begin
              tgt_valid = 1'b1;
              tgt_idx   = free_idx_q;
            end
`ifdef VOICE_STEAL_EN
            else if (old_found_q) begin
              tgt_valid = 1'b1;
              tgt_idx   = old_idx_q;
              stolen    = 1'b1;
            end
`endif
            if (tgt_valid) begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == tgt_idx) begin
                  vdiv_d[i]   = div_q;
                  vphase_d[i] = phase_q;
                  vnote_d[i]  = note_q;
                  gate_d[i]   = 1'b1;
                  apply_d[i]  = 1'b1;
`ifdef VOICE_STEAL_EN
                  age_d[i]    = '0;
                end else if (gate_q[i] && age_q[i] != {AGE_BITS{1'b1}}) begin
                  age_d[i]    = age_q[i] + 1'b1;
`endif
                end
              end
`ifdef VOICE_STEAL_EN
              steal_d = stolen;
`endif
            end else begin
              drop_d = 1'b1;
            end
          end
          CMD_NOTE_OFF: begin
            if (match_found_q) begin
              gate_d[match_idx_q] = 1'b0;
            end
          end
          CMD_ALL_OFF: begin
            gate_d = '0;
`ifdef VOICE_STEAL_EN
            for (int i = 0; i < NUM_VOICES; i++) begin
              age_d[i] = '0;
            end
`endif
          end
          default: ;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= ST_IDLE;
      type_q        <= '0;
      note_q        <= '0;
      div_q         <= '0;
      phase_q       <= '0;
      scan_idx_q    <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      gate_q        <= '0;
      apply_q       <= '0;
      drop_q        <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        vnote_q[i]  <= '0;
        vdiv_q[i]   <= DEFAULT_DIV;
        vphase_q[i] <= '0;
      end
`ifdef VOICE_STEAL_EN
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      steal_q       <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        age_q[i]    <= '0;
      end
`endif
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      note_q        <= note_d;
      div_q         <= div_d;
      phase_q       <= phase_d;
      scan_idx_q    <= scan_idx_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      gate_q        <= gate_d;
      apply_q       <= apply_d;
      drop_q        <= drop_d;
      vnote_q       <= vnote_d;
      vdiv_q        <= vdiv_d;
      vphase_q      <= vphase_d;
`ifdef VOICE_STEAL_EN
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      steal_q       <= steal_d;
      age_q         <= age_d;
`endif
    end
  end

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign voice_gate    = gate_q;
  assign voice_apply   = apply_q;
  assign drop_pulse    = drop_q;
`ifdef VOICE_STEAL_EN
  assign steal_pulse   = steal_q;
`else
  assign steal_pulse   = 1'b0;
`endif

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice_out
    assign voice_divider[16*gi +: 16]                   = vdiv_q[gi];
    assign voice_phase[NCO_ADDR_BITS*gi +: NCO_ADDR_BITS] = vphase_q[gi];
  end

endmodule

`default_nettype wire

// File: tb/tb_nco_voice_allocator.sv
//------------------------------------------------------------------------------
// tb_nco_voice_allocator
// Directed scenarios plus randomized commands against a note-table model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_nco_voice_allocator;

  localparam int NV   = 4;
  localparam int AB   = 8;
  localparam int AGEB = 4;
  localparam int AGE_MAX = (1 << AGEB) - 1;

  logic                sys_clk;
  logic                sys_rst;
  logic [16*NV-1:0]    voice_divider;
  logic [AB*NV-1:0]    voice_phase;
  logic [NV-1:0]       voice_apply;
  logic [NV-1:0]       voice_gate;
  logic                steal_pulse;
  logic                drop_pulse;

  nco_voice_allocator_if #(.NCO_ADDR_BITS(AB)) bus ();

  nco_voice_allocator #(
    .NUM_VOICES    (NV),
    .NCO_ADDR_BITS (AB),
    .AGE_BITS      (AGEB),
    .DEFAULT_DIV   (16'hFFFF)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cmd           (bus),
    .voice_divider (voice_divider),
    .voice_phase   (voice_phase),
    .voice_apply   (voice_apply),
    .voice_gate    (voice_gate),
    .steal_pulse   (steal_pulse),
    .drop_pulse    (drop_pulse)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Observations from the last command
  int            lat;
  logic          early;
  logic [NV-1:0] got_apply;
  logic          got_steal;
  logic          got_drop;

  // Reference note table
  logic          m_gate [NV];
  logic [6:0]    m_note [NV];
  logic [15:0]   m_div  [NV];
  logic [AB-1:0] m_ph   [NV];
  int            m_age  [NV];
  logic [NV-1:0] e_apply;
  logic          e_steal;
  logic          e_drop;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0; m_note[i] = '0; m_div[i] = 16'hFFFF; m_ph[i] = '0; m_age[i] = 0;
    end
  endtask

  task automatic model_cmd(input logic [1:0] t, input logic [6:0] n,
                           input logic [15:0] d, input logic [AB-1:0] p);
    int tgt;
    e_apply = '0; e_steal = 1'b0; e_drop = 1'b0;
    tgt = -1;
    for (int i = 0; i < NV; i++)
      if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
    if (t == 2'd0) begin
      for (int i = 0; i < NV; i++)
        if (tgt < 0 && !m_gate[i]) tgt = i;
`ifdef VOICE_STEAL_EN
      if (tgt < 0) begin
        tgt = 0;
        for (int i = 1; i < NV; i++)
          if (m_age[i] > m_age[tgt]) tgt = i;
        e_steal = 1'b1;
      end
`endif
      if (tgt < 0) begin
        e_drop = 1'b1;
      end else begin
        for (int i = 0; i < NV; i++)
          if (i != tgt && m_gate[i] && m_age[i] < AGE_MAX) m_age[i]++;
        m_gate[tgt] = 1'b1; m_note[tgt] = n; m_div[tgt] = d; m_ph[tgt] = p;
        m_age[tgt] = 0; e_apply[tgt] = 1'b1;
      end
    end else if (t == 2'd1) begin
      if (tgt >= 0) m_gate[tgt] = 1'b0;
    end else if (t == 2'd2) begin
      for (int i = 0; i < NV; i++) begin
        m_gate[i] = 1'b0; m_age[i] = 0;
      end
    end
  endtask

  function automatic logic [NV-1:0] m_gate_vec();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_gate[i];
    return v;
  endfunction

  function automatic logic [16*NV-1:0] m_div_bus();
    logic [16*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[16*i +: 16] = m_div[i];
    return v;
  endfunction

  function automatic logic [AB*NV-1:0] m_ph_bus();
    logic [AB*NV-1:0] v;
    for (int i = 0; i < NV; i++) v[AB*i +: AB] = m_ph[i];
    return v;
  endfunction

  task automatic do_reset();
    bus.cmd_valid = 1'b0; bus.cmd_type = '0; bus.cmd_note = '0;
    bus.cmd_divider = '0; bus.cmd_phase = '0;
    sys_rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    model_reset();
  endtask

  // Present one command, wait for acceptance and for ready to return.
  task automatic send_cmd(input logic [1:0] t, input logic [6:0] n,
                          input logic [15:0] d, input logic [AB-1:0] p);
    int w;
    model_cmd(t, n, d, p);
    bus.cmd_type = t; bus.cmd_note = n; bus.cmd_divider = d; bus.cmd_phase = p;
    bus.cmd_valid = 1'b1;
    w = 0;
    while (!bus.cmd_ready && w < 100) begin
      @(posedge sys_clk); #1; w++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout ready=%b required 1", bus.cmd_ready);
    end
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1; early = 1'b0;
    while (!bus.cmd_ready && lat < 64) begin
      early = early | (|voice_apply) | steal_pulse | drop_pulse;
      @(posedge sys_clk); #1; lat++;
    end
    got_apply = voice_apply; got_steal = steal_pulse; got_drop = drop_pulse;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.cmd_ready); end
    checks++; if (voice_gate !== '0) begin errors++; $display("FAIL reset_gate got %b exp 0", voice_gate); end
    checks++; if (voice_divider !== {NV{16'hFFFF}}) begin errors++; $display("FAIL reset_div got %h exp all FFFF", voice_divider); end
    checks++; if (voice_phase !== '0 || voice_apply !== '0) begin errors++; $display("FAIL reset_phase_apply got %h/%b exp 0/0", voice_phase, voice_apply); end
    checks++; if ({steal_pulse, drop_pulse} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {steal_pulse, drop_pulse}); end
  endtask

  task automatic test_note_on_basic();
    send_cmd(2'd0, 7'd60, 16'h0400, 8'h10);
    checks++; if (lat !== NV + 2) begin errors++; $display("FAIL on_latency got %0d exp %0d", lat, NV + 2); end
    checks++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL on_gate got %b exp 0001", voice_gate); end
    checks++; if (voice_divider[15:0] !== 16'h0400 || voice_phase[7:0] !== 8'h10) begin errors++; $display("FAIL on_v0 div %h ph %h exp 0400 10", voice_divider[15:0], voice_phase[7:0]); end
    checks++; if (got_apply !== 4'b0001 || early !== 1'b0) begin errors++; $display("FAIL on_apply got %b early %b exp 0001 0", got_apply, early); end
    @(posedge sys_clk); #1;
    checks++; if (voice_apply !== '0) begin errors++; $display("FAIL on_apply_one_cycle got %b exp 0", voice_apply); end
  endtask

  task automatic test_note_off();
    send_cmd(2'd0, 7'd62, 16'h0500, 8'h20);
    send_cmd(2'd0, 7'd64, 16'h0600, 8'h30);
    send_cmd(2'd0, 7'd67, 16'h0700, 8'h40);
    checks++; if (voice_gate !== 4'b1111) begin errors++; $display("FAIL fill_gate got %b exp 1111", voice_gate); end
    send_cmd(2'd1, 7'd62, 16'h0000, 8'h00);
    checks++; if (voice_gate !== 4'b1101) begin errors++; $display("FAIL off_gate got %b exp 1101", voice_gate); end
    checks++; if (voice_divider[31:16] !== 16'h0500 || got_apply !== '0) begin errors++; $display("FAIL off_v1 div %h apply %b exp 0500 0000", voice_divider[31:16], got_apply); end
    send_cmd(2'd0, 7'd69, 16'h0800, 8'h50);
    checks++; if (got_apply !== 4'b0010 || voice_divider[31:16] !== 16'h0800 || voice_gate !== 4'b1111) begin errors++; $display("FAIL reuse_v1 apply %b div %h gate %b exp 0010 0800 1111", got_apply, voice_divider[31:16], voice_gate); end
  endtask

  task automatic test_full();
    send_cmd(2'd0, 7'd72, 16'h0900, 8'h22);
`ifdef VOICE_STEAL_EN
    checks++; if (got_apply !== 4'b0001 || got_steal !== 1'b1 || got_drop !== 1'b0) begin errors++; $display("FAIL steal apply %b steal %b drop %b exp 0001 1 0", got_apply, got_steal, got_drop); end
    checks++; if (voice_divider[15:0] !== 16'h0900 || voice_phase[7:0] !== 8'h22) begin errors++; $display("FAIL steal_v0 div %h ph %h exp 0900 22", voice_divider[15:0], voice_phase[7:0]); end
`else
    checks++; if (got_apply !== 4'b0000 || got_steal !== 1'b0 || got_drop !== 1'b1) begin errors++; $display("FAIL drop apply %b steal %b drop %b exp 0000 0 1", got_apply, got_steal, got_drop); end
    checks++; if (voice_divider[15:0] !== 16'h0400 || voice_phase[7:0] !== 8'h10) begin errors++; $display("FAIL drop_v0 div %h ph %h exp 0400 10", voice_divider[15:0], voice_phase[7:0]); end
`endif
    checks++; if (voice_gate !== 4'b1111) begin errors++; $display("FAIL full_gate got %b exp 1111", voice_gate); end
    @(posedge sys_clk); #1;
    checks++; if ({steal_pulse, drop_pulse} !== 2'b00) begin errors++; $display("FAIL full_pulse_one_cycle got %b exp 00", {steal_pulse, drop_pulse}); end
  endtask

  task automatic test_retrigger();
    do_reset();
    send_cmd(2'd0, 7'd60, 16'h0400, 8'h10);
    send_cmd(2'd0, 7'd60, 16'h0420, 8'h33);
    checks++; if (got_apply !== 4'b0001 || got_steal !== 1'b0 || got_drop !== 1'b0) begin errors++; $display("FAIL retrig apply %b steal %b drop %b exp 0001 0 0", got_apply, got_steal, got_drop); end
    checks++; if (voice_gate !== 4'b0001 || voice_divider[15:0] !== 16'h0420) begin errors++; $display("FAIL retrig_state gate %b div %h exp 0001 0420", voice_gate, voice_divider[15:0]); end
    send_cmd(2'd2, 7'd0, 16'h0000, 8'h00);
    checks++; if (lat !== 2 || voice_gate !== '0) begin errors++; $display("FAIL all_off lat %0d gate %b exp 2 0000", lat, voice_gate); end
    checks++; if (voice_divider[15:0] !== 16'h0420) begin errors++; $display("FAIL all_off_div got %h exp 0420", voice_divider[15:0]); end
  endtask

  task automatic test_noop();
    send_cmd(2'd0, 7'd61, 16'h1234, 8'h44);
    send_cmd(2'd1, 7'd50, 16'hBEEF, 8'h77);
    checks++; if (voice_gate !== m_gate_vec() || voice_divider !== m_div_bus() || voice_phase !== m_ph_bus()) begin errors++; $display("FAIL noop_off gate %b exp %b div %h exp %h", voice_gate, m_gate_vec(), voice_divider, m_div_bus()); end
    checks++; if (got_apply !== '0 || got_steal !== 1'b0 || got_drop !== 1'b0 || early !== 1'b0 || lat !== NV + 2) begin errors++; $display("FAIL noop_off_pulses apply %b s %b d %b lat %0d exp 0 0 0 %0d", got_apply, got_steal, got_drop, lat, NV + 2); end
    send_cmd(2'd3, 7'd61, 16'h0001, 8'h01);
    checks++; if (lat !== 1 || voice_gate !== 4'b0001 || voice_divider !== m_div_bus()) begin errors++; $display("FAIL reserved lat %0d gate %b exp 1 0001", lat, voice_gate); end
    checks++; if (got_apply !== '0 || got_steal !== 1'b0 || got_drop !== 1'b0) begin errors++; $display("FAIL reserved_pulses apply %b s %b d %b exp 0", got_apply, got_steal, got_drop); end
  endtask

  task automatic test_reset_mid_scan();
    bus.cmd_type = 2'd0; bus.cmd_note = 7'd70; bus.cmd_divider = 16'h2222; bus.cmd_phase = 8'h55;
    bus.cmd_valid = 1'b1;
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge sys_clk); #1;
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL midscan_busy ready %b exp 0", bus.cmd_ready); end
    sys_rst = 1'b1;
    #1;
    checks++; if (voice_gate !== '0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midscan_async gate %b ready %b exp 0000 1", voice_gate, bus.cmd_ready); end
    checks++; if (voice_divider !== {NV{16'hFFFF}}) begin errors++; $display("FAIL midscan_div got %h exp all FFFF", voice_divider); end
    @(negedge sys_clk);
    sys_rst = 1'b0;
    model_reset();
    repeat (NV + 2) @(posedge sys_clk);
    #1;
    checks++; if (voice_gate !== '0 || voice_apply !== '0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midscan_abort gate %b apply %b ready %b exp 0 0 1", voice_gate, voice_apply, bus.cmd_ready); end
  endtask

  task automatic test_random();
    int r, exp_lat;
    logic [1:0] t;
    do_reset();
    for (int k = 0; k < 160; k++) begin
      r = $urandom_range(0, 15);
      t = (r < 8) ? 2'd0 : (r < 13) ? 2'd1 : (r == 13) ? 2'd2 : 2'd3;
      send_cmd(t, 7'(60 + $urandom_range(0, 7)), 16'($urandom), 8'($urandom));
      exp_lat = (t == 2'd2) ? 2 : (t == 2'd3) ? 1 : NV + 2;
      checks++;
      if (lat !== exp_lat || voice_gate !== m_gate_vec() || voice_divider !== m_div_bus() || voice_phase !== m_ph_bus()) begin
        errors++;
        $display("FAIL rand_state[%0d] t %0d lat %0d/%0d gate %b/%b div %h/%h", k, t, lat, exp_lat, voice_gate, m_gate_vec(), voice_divider, m_div_bus());
      end
      checks++;
      if (got_apply !== e_apply || got_steal !== e_steal || got_drop !== e_drop || early !== 1'b0) begin
        errors++;
        $display("FAIL rand_pulse[%0d] apply %b/%b steal %b/%b drop %b/%b early %b", k, got_apply, e_apply, got_steal, e_steal, got_drop, e_drop, early);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b1;
    bus.cmd_valid = 1'b0;
    test_reset();
    test_note_on_basic();
    test_note_off();
    test_full();
    test_retrigger();
    test_noop();
    test_reset_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
